// File: rtl/tetris_pkg.sv
// Shared types and constants for the tetromino bag generator.
package tetris_pkg;

  localparam int PIECE_W    = 3;
  localparam int NUM_PIECES = 7;

  localparam logic [NUM_PIECES-1:0] BAG_FULL = 7'h7F;

  typedef enum logic [PIECE_W-1:0] {
    PC_I = 3'd0,
    PC_O = 3'd1,
    PC_T = 3'd2,
    PC_S = 3'd3,
    PC_Z = 3'd4,
    PC_J = 3'd5,
    PC_L = 3'd6
  } piece_t;

  typedef enum logic {
    S_DRAW,
    S_HOLD
  } bag_state_t;

endpackage

// File: rtl/piece_bag_gen_prio_enc.sv
// Lowest-set-bit encoder over the bag mask; supplies the fallback pick after too many rejects.
module piece_prio_enc
  import tetris_pkg::*;
(
  input  logic [NUM_PIECES-1:0] mask_i,
  output logic [PIECE_W-1:0]    idx_o
);

  // Scan from the top down so the lowest set bit is the last one to win.
  always_comb begin
    idx_o = '0;
    for (int i = NUM_PIECES - 1; i >= 0; i--) begin
      if (mask_i[i]) idx_o = PIECE_W'(i);
    end
  end

endmodule

// File: rtl/piece_bag_gen.sv
// 7-bag tetromino generator fed by the LFSR stream, presenting pieces over valid/ready.
// Define PIECE_PREVIEW_EN to add a one-deep preview stage (preview_valid/preview_id).
module piece_bag_gen
  import tetris_pkg::*;
#(
  parameter int RAND_W    = 15,
  parameter int MAX_TRIES = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [RAND_W-1:0]     rand_in,
  input  logic                  piece_ready,
  output logic                  piece_valid,
  output logic [PIECE_W-1:0]    piece_id,
  output logic [NUM_PIECES-1:0] bag_mask
`ifdef PIECE_PREVIEW_EN
  ,
  output logic                  preview_valid,
  output logic [PIECE_W-1:0]    preview_id
`endif
);

  localparam int TRY_W = $clog2(MAX_TRIES);
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

  bag_state_t            state_q, state_d;
  piece_t                piece_id_q, piece_id_d;
  logic [NUM_PIECES-1:0] bag_q, bag_d;
  logic [TRY_W-1:0]      try_q, try_d;

  logic [PIECE_W-1:0]    cand, fb_id, pick;
  logic [NUM_PIECES:0]   mask_ext;
  logic [NUM_PIECES-1:0] mask_clr, mask_after;
  logic                  in_bag, take;
  logic                  rand_unused;

  // Only the low bits pick a piece; the upper LFSR bits are deliberately ignored.
  assign cand        = rand_in[PIECE_W-1:0];
  assign rand_unused = ^rand_in[RAND_W-1:PIECE_W];

  // The extra zero bit makes the out-of-range candidate (7) read as "not in bag".
  assign mask_ext   = {1'b0, bag_q};
  assign in_bag     = (cand < PIECE_W'(NUM_PIECES)) && mask_ext[cand];
  assign take       = in_bag || (try_q == LAST_TRY);
  assign pick       = in_bag ? cand : fb_id;
  assign mask_clr   = bag_q & ~(NUM_PIECES'(1) << pick);
  assign mask_after = (mask_clr == '0) ? BAG_FULL : mask_clr;

  piece_prio_enc u_fallback (
    .mask_i (bag_q),
    .idx_o  (fb_id)
  );

`ifdef PIECE_PREVIEW_EN
  logic   prev_valid_q, prev_valid_d;
  piece_t prev_id_q, prev_id_d;
  logic   head_v;

  always_comb begin
    state_d      = state_q;
    piece_id_d   = piece_id_q;
    bag_d        = bag_q;
    try_d        = try_q;
    prev_valid_d = prev_valid_q;
    prev_id_d    = prev_id_q;
    head_v       = (state_q == S_HOLD) && !piece_ready;
    // Promote the preview into the head slot as soon as the head frees up.
    if (!head_v && prev_valid_q) begin
      head_v       = 1'b1;
      piece_id_d   = prev_id_q;
      prev_valid_d = 1'b0;
    end
    if (!prev_valid_d) begin
      if (take) begin
        bag_d = mask_after;
        try_d = '0;
        if (!head_v) begin
          head_v     = 1'b1;
          piece_id_d = piece_t'(pick);
        end else begin
          prev_valid_d = 1'b1;
          prev_id_d    = piece_t'(pick);
        end
      end else begin
        try_d = try_q + 1'b1;
      end
    end
    state_d = head_v ? S_HOLD : S_DRAW;
  end

  assign preview_valid = prev_valid_q;
  assign preview_id    = prev_id_q;
`else
  always_comb begin
    state_d    = state_q;
    piece_id_d = piece_id_q;
    bag_d      = bag_q;
    try_d      = try_q;
    case (state_q)
      S_DRAW: begin
        if (take) begin
          piece_id_d = piece_t'(pick);
          bag_d      = mask_after;
          try_d      = '0;
          state_d    = S_HOLD;
        end else begin
          try_d = try_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (piece_ready) state_d = S_DRAW;
      end
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_DRAW;
      piece_id_q   <= PC_I;
      bag_q        <= BAG_FULL;
      try_q        <= '0;
`ifdef PIECE_PREVIEW_EN
      prev_valid_q <= 1'b0;
      prev_id_q    <= PC_I;
`endif
    end else begin
      state_q      <= state_d;
      piece_id_q   <= piece_id_d;
      bag_q        <= bag_d;
      try_q        <= try_d;
`ifdef PIECE_PREVIEW_EN
      prev_valid_q <= prev_valid_d;
      prev_id_q    <= prev_id_d;
`endif
    end
  end

  assign piece_valid = (state_q == S_HOLD);
  assign piece_id    = piece_id_q;
  assign bag_mask    = bag_q;

endmodule

// File: tb/tb_piece_bag_gen.sv
// Directed bench for piece_bag_gen: vector table for bag order plus hand-written reject/hold/reset sequences.
module tb_piece_bag_gen;

  logic        clk;
  logic        reset;
  logic [14:0] rand_in;
  logic        piece_ready;
  logic        piece_valid;
  logic [2:0]  piece_id;
  logic [6:0]  bag_mask;
`ifdef PIECE_PREVIEW_EN
  logic        preview_valid;
  logic [2:0]  preview_id;
`endif

  int passed = 0;
  int total  = 0;

  piece_bag_gen dut (
    .clk         (clk),
    .reset       (reset),
    .rand_in     (rand_in),
    .piece_ready (piece_ready),
    .piece_valid (piece_valid),
    .piece_id    (piece_id),
    .bag_mask    (bag_mask)
`ifdef PIECE_PREVIEW_EN
    ,
    .preview_valid (preview_valid),
    .preview_id    (preview_id)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] r;
    logic       rdy;
    logic       ev;
    logic [2:0] eid;
    logic [6:0] emask;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_rand(input logic [2:0] r);
    rand_in = {12'($urandom), r};
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) tick();
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    piece_ready = 1'b0;
    rand_in     = 15'd3;

    // Bag walk with interleaved rejects: ids 0..6, refill on the last one.
    vecs[0]  = '{3'd0, 1'b1, 1'b1, 3'd0, 7'h7E};
    vecs[1]  = '{3'd1, 1'b1, 1'b0, 3'd0, 7'h7E};
    vecs[2]  = '{3'd0, 1'b1, 1'b0, 3'd0, 7'h7E};
    vecs[3]  = '{3'd7, 1'b1, 1'b0, 3'd0, 7'h7E};
    vecs[4]  = '{3'd1, 1'b1, 1'b1, 3'd1, 7'h7C};
    vecs[5]  = '{3'd2, 1'b1, 1'b0, 3'd1, 7'h7C};
    vecs[6]  = '{3'd2, 1'b1, 1'b1, 3'd2, 7'h78};
    vecs[7]  = '{3'd3, 1'b1, 1'b0, 3'd2, 7'h78};
    vecs[8]  = '{3'd3, 1'b1, 1'b1, 3'd3, 7'h70};
    vecs[9]  = '{3'd4, 1'b1, 1'b0, 3'd3, 7'h70};
    vecs[10] = '{3'd4, 1'b1, 1'b1, 3'd4, 7'h60};
    vecs[11] = '{3'd5, 1'b1, 1'b0, 3'd4, 7'h60};
    vecs[12] = '{3'd5, 1'b1, 1'b1, 3'd5, 7'h40};
    vecs[13] = '{3'd6, 1'b1, 1'b0, 3'd5, 7'h40};
    vecs[14] = '{3'd6, 1'b1, 1'b1, 3'd6, 7'h7F};
    vecs[15] = '{3'd0, 1'b1, 1'b0, 3'd6, 7'h7F};
    vecs[16] = '{3'd0, 1'b1, 1'b1, 3'd0, 7'h7E};

    // Reset state, then first draw.
    rand_in = 15'd3;
    do_reset(2);
    check("rst_valid", 32'(piece_valid), 32'd0);
    check("rst_id", 32'(piece_id), 32'd0);
    check("rst_mask", 32'(bag_mask), 32'h7F);
    tick();
    $display("txn first_draw: valid=%0d id=%0d mask=%02h", piece_valid, piece_id, bag_mask);
    check("first_valid", 32'(piece_valid), 32'd1);
    check("first_id", 32'(piece_id), 32'd3);
    check("first_mask", 32'(bag_mask), 32'h77);

`ifndef PIECE_PREVIEW_EN
    // Stall with random stream: held piece and bag must not move.
    for (int i = 0; i < 20; i++) begin
      rand_in = 15'($urandom);
      tick();
      $display("txn hold %0d: rand=%04h valid=%0d id=%0d mask=%02h", i, rand_in, piece_valid, piece_id, bag_mask);
      check("hold_valid", 32'(piece_valid), 32'd1);
      check("hold_id", 32'(piece_id), 32'd3);
      check("hold_mask", 32'(bag_mask), 32'h77);
    end

    // Table-driven bag order.
    do_reset(2);
    for (int i = 0; i < 17; i++) begin
      set_rand(vecs[i].r);
      piece_ready = vecs[i].rdy;
      tick();
      $display("txn vec %0d: rand=%0d ready=%0d -> valid=%0d id=%0d mask=%02h",
               i, vecs[i].r, vecs[i].rdy, piece_valid, piece_id, bag_mask);
      check($sformatf("vec%0d_valid", i), 32'(piece_valid), 32'(vecs[i].ev));
      check($sformatf("vec%0d_id", i), 32'(piece_id), 32'(vecs[i].eid));
      check($sformatf("vec%0d_mask", i), 32'(bag_mask), 32'(vecs[i].emask));
    end

    // Constant out-of-range candidate: 8 rejected attempts, fallback picks ID 0.
    piece_ready = 1'b0;
    set_rand(3'd7);
    do_reset(2);
    for (int i = 1; i <= 7; i++) begin
      set_rand(3'd7);
      tick();
      check($sformatf("fb7_wait%0d", i), 32'(piece_valid), 32'd0);
    end
    set_rand(3'd7);
    tick();
    $display("txn fallback7: valid=%0d id=%0d mask=%02h", piece_valid, piece_id, bag_mask);
    check("fb7_valid", 32'(piece_valid), 32'd1);
    check("fb7_id", 32'(piece_id), 32'd0);
    check("fb7_mask", 32'(bag_mask), 32'h7E);

    // Consume, then constant 0 (already used): fallback yields ID 1.
    piece_ready = 1'b1;
    tick();
    check("fb0_consumed", 32'(piece_valid), 32'd0);
    piece_ready = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      set_rand(3'd0);
      tick();
      check($sformatf("fb0_wait%0d", i), 32'(piece_valid), 32'd0);
    end
    set_rand(3'd0);
    tick();
    $display("txn fallback0: valid=%0d id=%0d mask=%02h", piece_valid, piece_id, bag_mask);
    check("fb0_valid", 32'(piece_valid), 32'd1);
    check("fb0_id", 32'(piece_id), 32'd1);
    check("fb0_mask", 32'(bag_mask), 32'h7C);

    // Build bag_mask=0C in hold, then reset mid-hold.
    for (int p = 4; p <= 6; p++) begin
      piece_ready = 1'b1;
      tick();
      piece_ready = 1'b0;
      set_rand(3'(p));
      tick();
    end
    check("pre_rst_valid", 32'(piece_valid), 32'd1);
    check("pre_rst_id", 32'(piece_id), 32'd6);
    check("pre_rst_mask", 32'(bag_mask), 32'h0C);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    $display("txn mid_hold_reset: valid=%0d id=%0d mask=%02h", piece_valid, piece_id, bag_mask);
    check("hold_rst_valid", 32'(piece_valid), 32'd0);
    check("hold_rst_mask", 32'(bag_mask), 32'h7F);
    set_rand(3'd2);
    tick();
    check("post_rst_id", 32'(piece_id), 32'd2);
    check("post_rst_mask", 32'(bag_mask), 32'h7B);
`else
    // Preview build: constant ready gives one new piece per cycle.
    piece_ready = 1'b1;
    do_reset(2);
    check("pv_rst_valid", 32'(preview_valid), 32'd0);
    for (int i = 0; i < 7; i++) begin
      set_rand(3'(i));
      tick();
      $display("txn preview %0d: valid=%0d id=%0d pv=%0d", i, piece_valid, piece_id, preview_valid);
      check($sformatf("pv%0d_valid", i), 32'(piece_valid), 32'd1);
      check($sformatf("pv%0d_id", i), 32'(piece_id), 32'(i));
    end
    check("pv_refill_mask", 32'(bag_mask), 32'h7F);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
